// File: rtl/iob_fifo_sync_asym_ctrl_pkg.sv
// Shared width/address/increment helpers for the asymmetric FIFO controller and its RAM.
// The derived widths are functions so that port declarations can use them directly.
`ifndef IOB_MAX
`define IOB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif
`ifndef IOB_MIN
`define IOB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

package iob_fifo_sync_asym_ctrl_pkg;

  function automatic int max_dw(input int a, input int b);
    return `IOB_MAX(a, b);
  endfunction

  function automatic int min_dw(input int a, input int b);
    return `IOB_MIN(a, b);
  endfunction

  // Number of minimum-width units carried by one word of width dw.
  function automatic int unit_incr(input int dw, input int w_dw, input int r_dw);
    return dw / min_dw(w_dw, r_dw);
  endfunction

  function automatic int port_addr_w(input int dw, input int w_dw, input int r_dw,
                                     input int addr_w);
    return addr_w - $clog2(unit_incr(dw, w_dw, r_dw));
  endfunction

  localparam logic RST_W_FULL  = 1'b0;
  localparam logic RST_R_EMPTY = 1'b1;
  localparam logic RST_R_VALID = 1'b0;

endpackage

// File: rtl/iob_fifo_asym_level.sv
// Fill level in minimum-width units, with full/empty flags registered from the next level.
module iob_fifo_asym_level
  import iob_fifo_sync_asym_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int W_INCR = 4,
  parameter int R_INCR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc_w,
  input  logic            acc_r,
  output logic [ADDR_W:0] level,
  output logic            w_full,
  output logic            r_empty
);

  localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] W_STEP  = (ADDR_W + 1)'(W_INCR);
  localparam logic [ADDR_W:0] R_STEP  = (ADDR_W + 1)'(R_INCR);
  localparam logic [ADDR_W:0] FULL_TH = CAP - W_STEP;

  logic [ADDR_W:0] level_q, level_d;
  logic            w_full_q, w_full_d;
  logic            r_empty_q, r_empty_d;

  always_comb begin
    level_d   = level_q + (acc_w ? W_STEP : '0) - (acc_r ? R_STEP : '0);
    w_full_d  = (level_d > FULL_TH);
    r_empty_d = (level_d < R_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q   <= '0;
      w_full_q  <= RST_W_FULL;
      r_empty_q <= RST_R_EMPTY;
    end else begin
      level_q   <= level_d;
      w_full_q  <= w_full_d;
      r_empty_q <= r_empty_d;
    end
  end

  assign level   = level_q;
  assign w_full  = w_full_q;
  assign r_empty = r_empty_q;

endmodule

// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Width-converting single-clock FIFO controller driving an iob_ram_2p_asym through its user ports.
// Define IOB_FIFO_ASYM_ERR_EN to add sticky overflow/underflow outputs.
module iob_fifo_sync_asym_ctrl
  import iob_fifo_sync_asym_ctrl_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                r_empty,
  output logic [ADDR_W:0]     level,
  output logic                ram_w_en,
  output logic [port_addr_w(W_DATA_W, W_DATA_W, R_DATA_W, ADDR_W)-1:0] ram_w_addr,
  output logic [W_DATA_W-1:0] ram_w_data,
  output logic                ram_r_en,
  output logic [port_addr_w(R_DATA_W, W_DATA_W, R_DATA_W, ADDR_W)-1:0] ram_r_addr,
  input  logic [R_DATA_W-1:0] ram_r_data
`ifdef IOB_FIFO_ASYM_ERR_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam int W_ADDR_W = port_addr_w(W_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);
  localparam int R_ADDR_W = port_addr_w(R_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);
  localparam int W_INCR   = unit_incr(W_DATA_W, W_DATA_W, R_DATA_W);
  localparam int R_INCR   = unit_incr(R_DATA_W, W_DATA_W, R_DATA_W);

  logic                acc_w, acc_r;
  logic [W_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic                r_valid_q;

  assign acc_w = w_en & ~w_full;
  assign acc_r = r_en & ~r_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (acc_w) wptr_d = wptr_q + W_ADDR_W'(1);
    if (acc_r) rptr_d = rptr_q + R_ADDR_W'(1);
  end

  // Pointers wrap naturally at their own width; reset also kills an in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      r_valid_q <= RST_R_VALID;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      r_valid_q <= acc_r;
    end
  end

  iob_fifo_asym_level #(
    .ADDR_W (ADDR_W),
    .W_INCR (W_INCR),
    .R_INCR (R_INCR)
  ) u_level (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_w   (acc_w),
    .acc_r   (acc_r),
    .level   (level),
    .w_full  (w_full),
    .r_empty (r_empty)
  );

  assign ram_w_en   = acc_w;
  assign ram_w_addr = wptr_q;
  assign ram_w_data = w_data;
  assign ram_r_en   = acc_r;
  assign ram_r_addr = rptr_q;
  assign r_data     = ram_r_data;
  assign r_valid    = r_valid_q;

`ifdef IOB_FIFO_ASYM_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_en & w_full)  overflow_q  <= 1'b1;
      if (r_en & r_empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// Self-checking bench: 32->8 instance against a byte-queue reference model, plus an 8->32 instance.
module tb_iob_fifo_sync_asym_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit write, 8-bit read instance
  logic        a_w_en, a_w_full, a_r_en, a_r_valid, a_r_empty;
  logic [31:0] a_w_data, a_ram_w_data;
  logic [7:0]  a_r_data, a_ram_r_data;
  logic [10:0] a_level;
  logic        a_ram_w_en, a_ram_r_en;
  logic [7:0]  a_ram_w_addr;
  logic [9:0]  a_ram_r_addr;

  // 8-bit write, 32-bit read instance
  logic        b_w_en, b_w_full, b_r_en, b_r_valid, b_r_empty;
  logic [7:0]  b_w_data, b_ram_w_data;
  logic [31:0] b_r_data, b_ram_r_data;
  logic [10:0] b_level;
  logic        b_ram_w_en, b_ram_r_en;
  logic [9:0]  b_ram_w_addr;
  logic [7:0]  b_ram_r_addr;

`ifdef IOB_FIFO_ASYM_ERR_EN
  logic a_overflow, a_underflow, b_overflow, b_underflow;
`endif

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
    .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid), .r_empty(a_r_empty),
    .level(a_level), .ram_w_en(a_ram_w_en), .ram_w_addr(a_ram_w_addr),
    .ram_w_data(a_ram_w_data), .ram_r_en(a_ram_r_en), .ram_r_addr(a_ram_r_addr),
    .ram_r_data(a_ram_r_data)
`ifdef IOB_FIFO_ASYM_ERR_EN
    , .overflow(a_overflow), .underflow(a_underflow)
`endif
  );

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
    .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_r_valid), .r_empty(b_r_empty),
    .level(b_level), .ram_w_en(b_ram_w_en), .ram_w_addr(b_ram_w_addr),
    .ram_w_data(b_ram_w_data), .ram_r_en(b_ram_r_en), .ram_r_addr(b_ram_r_addr),
    .ram_r_data(b_ram_r_data)
`ifdef IOB_FIFO_ASYM_ERR_EN
    , .overflow(b_overflow), .underflow(b_underflow)
`endif
  );

  // Little-endian asymmetric RAMs with a registered read port
  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (a_ram_w_en)
      for (int k = 0; k < 4; k++) mem_a[int'(a_ram_w_addr) * 4 + k] <= a_ram_w_data[8*k +: 8];
    if (a_ram_r_en) a_ram_r_data <= mem_a[a_ram_r_addr];
  end

  always @(posedge clk) begin
    if (b_ram_w_en) mem_b[b_ram_w_addr] <= b_ram_w_data;
    if (b_ram_r_en)
      b_ram_r_data <= {mem_b[int'(b_ram_r_addr) * 4 + 3], mem_b[int'(b_ram_r_addr) * 4 + 2],
                       mem_b[int'(b_ram_r_addr) * 4 + 1], mem_b[int'(b_ram_r_addr) * 4]};
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO of bytes, plus word counts for the RAM addresses
  logic [7:0] q[$];
  int         m_wcnt, m_rcnt;
  logic [7:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock on instance A; entered and left at a falling edge.
  task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
    logic aw, ar;
    a_w_en = we; a_w_data = wd; a_r_en = re;
    #1;
    aw = we && !(q.size() > 1024 - 4);
    ar = re && (q.size() >= 1);
    chk("ram_w_en", a_ram_w_en, aw);
    chk("ram_r_en", a_ram_r_en, ar);
    if (aw) begin
      chk("ram_w_addr", a_ram_w_addr, m_wcnt % 256);
      chk("ram_w_data", a_ram_w_data, wd);
    end
    if (ar) chk("ram_r_addr", a_ram_r_addr, m_rcnt % 1024);
    @(posedge clk);
    #1;
    if (ar) begin
      last_rd = q.pop_front();
      m_rcnt++;
    end
    if (aw) begin
      for (int k = 0; k < 4; k++) q.push_back(wd[8*k +: 8]);
      m_wcnt++;
    end
    chk("r_valid", a_r_valid, ar);
    if (ar) chk("r_data", a_r_data, last_rd);
    chk("level", a_level, q.size());
    chk("w_full", a_w_full, q.size() > 1024 - 4);
    chk("r_empty", a_r_empty, q.size() < 1);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic re);
    rst_n = 1'b0;
    a_w_en = 1'b0; a_r_en = re; b_w_en = 1'b0; b_r_en = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_wcnt = 0;
    m_rcnt = 0;
    chk("rst_level", a_level, 0);
    chk("rst_r_empty", a_r_empty, 1);
    chk("rst_w_full", a_w_full, 0);
    chk("rst_r_valid", a_r_valid, 0);
    chk("rst_ram_r_en", a_ram_r_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_r_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_w_en = 1'b0; a_w_data = '0; a_r_en = 1'b0;
    b_w_en = 1'b0; b_w_data = '0; b_r_en = 1'b0;
    @(negedge clk);
    do_reset(1'b0);
    chk("b_rst_level", b_level, 0);
    chk("b_rst_r_empty", b_r_empty, 1);

    // Single word, read back one byte at a time, low byte first
    cyc(1'b1, 32'h0000000A, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("first_byte", last_rd, 8'h0A);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    chk("drained_level", a_level, 0);

    // Fill to capacity, attempt one more, then drain everything
    do_reset(1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 32'(i + 10), 1'b0);
    chk("full_flag", a_w_full, 1);
    chk("full_level", a_level, 1024);
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    chk("full_level_hold", a_level, 1024);
`ifdef IOB_FIFO_ASYM_ERR_EN
    chk("overflow", a_overflow, 1);
`endif
    for (int i = 0; i < 1024; i++) cyc(1'b0, '0, 1'b1);
    chk("end_empty", a_r_empty, 1);
    chk("wptr_wrap", a_ram_w_addr, 0);
    chk("rptr_wrap", a_ram_r_addr, 0);

    // Simultaneous push/pop, then randomized traffic
    cyc(1'b1, $urandom, 1'b0);
    cyc(1'b1, $urandom, 1'b1);
    chk("simul_level", a_level, 7);
    for (int i = 0; i < 100; i++) cyc(1'($urandom % 2), $urandom, 1'($urandom % 2));

    // Drain, then pop while empty
    for (int i = 0; i < 1100 && q.size() != 0; i++) cyc(1'b0, '0, 1'b1);
    chk("pre_underflow_level", a_level, 0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
`ifdef IOB_FIFO_ASYM_ERR_EN
    chk("underflow", a_underflow, 1);
`endif

    // Reset mid-stream with a pop requested on the reset edge
    do_reset(1'b0);
    for (int i = 0; i < 128; i++) cyc(1'b1, $urandom, 1'b0);
    chk("half_level", a_level, 512);
    do_reset(1'b1);
`ifdef IOB_FIFO_ASYM_ERR_EN
    chk("underflow_cleared", a_underflow, 0);
`endif
    cyc(1'b1, 32'h11223344, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_byte", last_rd, 8'h44);

    // Narrow-write, wide-read instance
    for (int i = 0; i < 4; i++) begin
      b_w_en = 1'b1; b_w_data = 8'(i + 1);
      @(posedge clk);
      #1;
      chk("b_level", b_level, i + 1);
      chk("b_r_empty", b_r_empty, i < 3);
      @(negedge clk);
    end
    b_w_en = 1'b0; b_r_en = 1'b1;
    #1;
    chk("b_ram_r_en", b_ram_r_en, 1);
    @(posedge clk);
    #1;
    b_r_en = 1'b0;
    chk("b_r_valid", b_r_valid, 1);
    chk("b_r_data", b_r_data, 32'h04030201);
    chk("b_level_after", b_level, 0);
    chk("b_empty_after", b_r_empty, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
